muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequences the shared multiply/divide resource and owns the architectural HI/LO registers.
//  Sits beside the ALU in EX and is fed the decoded alu_op plus operand values.
//  Executes MULT/MULTU (pipelined multiplier) and DIV/DIVU (iterative divider) over several cycles, holding the pipeline with stall_o.
//  MTHI/MTLO are single-cycle writes; MFHI/MFLO are combinational reads.
// PARAMETERS
//  MUL_LATENCY  2  cycles spent in MUL state after the start cycle (>=1)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous reset, active-high
//  op_valid     in   1   EX holds a valid, non-killed instruction
//  alu_op       in   6   decoded ALU op (`ALU_MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO; others ignored)
//  rs_data      in   32  operand A (dividend / multiplicand / MT source)
//  rt_data      in   32  operand B (divisor / multiplier)
//  ex_flush     in   1   kill the EX instruction and any in-flight muldiv op
//  stall_o      out  1   hold EX and all earlier stages
//  busy_o       out  1   state != IDLE
//  hi_o         out  32  architectural HI
//  lo_o         out  32  architectural LO
//  mf_result_o  out  32  MFHI -> hi_o, MFLO -> lo_o, else 0
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, stall_o=0, busy_o=0, divider idle.
//  FSM states: IDLE, MUL, DIV.
//  IDLE, op_valid & MULT/MULTU & ~ex_flush:
//   - latch operands; stall_o=1 (comb).
//   - Next state MUL with cnt=MUL_LATENCY-1.
//  MUL:
//   - stall_o=(cnt!=0); cnt decrements.
//   - At cnt==0: {hi,lo} <= 64-bit product (signed for MULT), -> IDLE.
//   - EX residency = MUL_LATENCY+1 cycles; new HI/LO visible the following cycle.
//  IDLE, op_valid & DIV/DIVU & ~ex_flush:
//   - stall_o=1; start pulse to divider with |rs|,|rt| (raw values for DIVU).
//   - Next state DIV.
//  DIV:
//   - stall_o=~div_done.
//   - On div_done: lo <= quotient, hi <= remainder after sign fix, -> IDLE.
//   - Sign fix (DIV only): Q negated iff rs[31]^rt[31]; R takes sign of rs.
//   - Divider runs 32 cycles, so EX residency = 33 cycles.
//  Divide corner cases: no exception, fixed latency.
//   - rt==0: magnitude result Q=32'hFFFFFFFF, R=|rs|, then sign fix.
//   - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
//  Other ops:
//   - IDLE, op_valid & MTHI/MTLO & ~ex_flush: hi/lo <= rs_data at the edge; stall_o=0.
//   - MFHI/MFLO: combinational, never stalls. No op can reach EX while busy, since EX is stalled.
//  Completion cycle (stall_o=0): the held instruction leaves EX; op_valid that cycle never restarts an op.
//  ex_flush:
//   - Any state -> IDLE at the next edge; divider aborted; hi/lo unchanged.
//   - stall_o forced 0 while ex_flush=1.
//   - ex_flush on the completion cycle also suppresses the HI/LO write.
//  rst mid-operation: same as reset; in-flight result discarded.
// STRUCTURE
//  Shared package (cpu_defs_pkg): muldiv_state_t enum {IDLE,MUL,DIV}.
//  ALU op codes stay in alu_op.vh.
//  Sub-module div_radix2:
//   - Unsigned restoring divider with ports clk, rst, start, abort, dividend[31:0], divisor[31:0], quotient[31:0], remainder[31:0], done.
//   - done pulses for one cycle, 32 cycles after start.
//  Multiplier: registered signed 33x33 product in a MUL_LATENCY-deep shift pipe inside this module.
// TESTING
//  1. MULT rs=-3, rt=7, MUL_LATENCY=2 -> stall_o high 2 cycles; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
//  2. DIV rs=-7, rt=2 -> stall_o high 32 cycles; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
//     DIVU 100/7 -> LO=14, HI=2.
//  3. DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5.
//     DIV 32'h80000000/-1 -> LO=32'h80000000, HI=0; no hang.
//  4. MTHI 32'h1234 then MFHI in the next cycle -> mf_result_o=32'h1234.
//     MULT immediately followed by MFLO -> MFLO returns the new LO.
//  5. ex_flush at cycle 10 of a DIV -> IDLE next cycle, stall_o=0, HI/LO keep their prior values.
//     A new DIV then completes correctly.
//  6. rst asserted mid-MUL -> hi=lo=0, IDLE, stall_o=0.
//     Back-to-back MULT,DIV -> each op starts exactly once.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and ALU op encodings for the multiply/divide controller.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } muldiv_state_t;

    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Unsigned restoring divider: one quotient bit per cycle, done pulses 32 cycles after start.
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] rem_q, quo_q, dvsr_q;
    logic [4:0]  cnt_q;
    logic        busy_q, done_q;

    logic [31:0] rem_in, quo_in, dvsr_in;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_nx, quo_nx;

    // The start cycle already performs the first step so the result lands on cycle 32.
    always_comb begin
        rem_in  = start ? 32'd0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvsr_in = start ? divisor : dvsr_q;
        rem_sh  = {rem_in, quo_in[31]};
        fits    = (rem_sh >= {1'b0, dvsr_in});
        rem_nx  = fits ? (rem_sh[31:0] - dvsr_in) : rem_sh[31:0];
        quo_nx  = {quo_in[30:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            dvsr_q <= 32'd0;
            cnt_q  <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                busy_q <= 1'b0;
                cnt_q  <= 5'd0;
            end else if (start) begin
                rem_q  <= rem_nx;
                quo_q  <= quo_nx;
                dvsr_q <= divisor;
                cnt_q  <= 5'd31;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer beside the EX-stage ALU; owns HI/LO and stalls EX while busy.
//  state | meaning
//  IDLE  | no op in flight; MT*/MF* serviced, MULT/DIV accepted
//  MUL   | product travelling down the multiplier pipe
//  DIV   | divider iterating, waiting for done
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [5:0]  alu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_flush,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] mf_result_o
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    muldiv_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       hi_q, lo_q;
    logic              q_neg_q, r_neg_q;
    logic [63:0]       mul_pipe_q [MUL_LATENCY];

    logic              is_mul, is_div, is_signed, div_start;
    logic signed [32:0] mul_a, mul_b;
    logic signed [65:0] mul_prod;
    logic              unused_prod_msbs;
    logic [31:0]       div_quo, div_rem, quo_fix, rem_fix;
    logic              div_done;

    assign is_mul    = (alu_op == ALU_MULT) || (alu_op == ALU_MULTU);
    assign is_div    = (alu_op == ALU_DIV) || (alu_op == ALU_DIVU);
    assign is_signed = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
    assign div_start = (state_q == IDLE) && op_valid && is_div && !ex_flush;

    // 33-bit operands let one signed multiplier serve both MULT and MULTU.
    assign mul_a            = {is_signed & rs_data[31], rs_data};
    assign mul_b            = {is_signed & rt_data[31], rt_data};
    assign mul_prod         = mul_a * mul_b;
    assign unused_prod_msbs = ^mul_prod[65:64];

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (ex_flush),
        .dividend  (mag32(rs_data, is_signed)),
        .divisor   (mag32(rt_data, is_signed)),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    assign quo_fix = q_neg_q ? (~div_quo + 32'd1) : div_quo;
    assign rem_fix = r_neg_q ? (~div_rem + 32'd1) : div_rem;

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:    stall_o = op_valid && (is_mul || is_div);
            MUL:     stall_o = (cnt_q != '0);
            DIV:     stall_o = !div_done;
            default: stall_o = 1'b0;
        endcase
        if (ex_flush) stall_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LATENCY; i++) mul_pipe_q[i] <= 64'd0;
        end else begin
            mul_pipe_q[0] <= mul_prod[63:0];
            for (int i = 1; i < MUL_LATENCY; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (ex_flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        if (is_mul) begin
                            state_q <= MUL;
                            cnt_q   <= CNT_W'(MUL_LATENCY - 1);
                        end else if (is_div) begin
                            state_q <= DIV;
                            q_neg_q <= is_signed && (rs_data[31] ^ rt_data[31]);
                            r_neg_q <= is_signed && rs_data[31];
                        end else if (alu_op == ALU_MTHI) begin
                            hi_q <= rs_data;
                        end else if (alu_op == ALU_MTLO) begin
                            lo_q <= rs_data;
                        end
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= mul_pipe_q[MUL_LATENCY-1];
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DIV: begin
                    if (div_done) begin
                        lo_q    <= quo_fix;
                        hi_q    <= rem_fix;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign mf_result_o = (alu_op == ALU_MFHI) ? hi_q :
                         (alu_op == ALU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with a HI/LO result scoreboard.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, op_valid, ex_flush;
    logic [5:0]  alu_op;
    logic [31:0] rs_data, rt_data;
    logic        stall_o, busy_o;
    logic [31:0] hi_o, lo_o, mf_result_o;

    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] sb_q[$];
    logic [31:0] cur_hi, cur_lo;
    logic [63:0] prior;

    muldiv_ctrl #(.MUL_LATENCY(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .alu_op      (alu_op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .ex_flush    (ex_flush),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .mf_result_o (mf_result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference semantics: {HI, LO} for each op.
    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ALU_MULT:  return 64'(sa * sb);
            ALU_MULTU: return {32'd0, a} * {32'd0, b};
            ALU_DIVU:  return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            ALU_DIV: begin
                if (b == 32'd0) begin
                    q = 32'hFFFFFFFF;
                    r = a[31] ? -a : a;
                    if (a[31]) begin
                        q = -q;
                        r = -r;
                    end
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the completion edge.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stalls, input string tag);
        int          stalls;
        bit          done;
        logic [63:0] exp;
        sb_q.push_back(model(op, a, b));
        op_valid = 1'b1;
        alu_op   = op;
        rs_data  = a;
        rt_data  = b;
        stalls   = 0;
        done     = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (stall_o) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        chk($sformatf("%s_done", tag), 64'(done), 64'd1);
        chk($sformatf("%s_stalls", tag), 64'(stalls), 64'(exp_stalls));
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        chk($sformatf("%s_hilo", tag), {hi_o, lo_o}, exp);
        chk($sformatf("%s_idle", tag), 64'(busy_o), 64'd0);
        op_valid = 1'b0;
        alu_op   = 6'h00;
        cur_hi   = exp[63:32];
        cur_lo   = exp[31:0];
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        ex_flush = 1'b0;
        alu_op   = 6'h00;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_mf", 64'(mf_result_o), 64'd0);
        @(posedge clk);
        #1;

        run_op(ALU_MULT,  32'hFFFFFFFD, 32'd7,        2,  "mult_neg");
        run_op(ALU_DIV,   32'hFFFFFFF9, 32'd2,        32, "div_neg");
        run_op(ALU_DIVU,  32'd100,      32'd7,        32, "divu");
        run_op(ALU_DIVU,  32'd5,        32'd0,        32, "divu_by0");
        run_op(ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32, "div_ovf");
        run_op(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  "multu_max");
        run_op(ALU_DIV,   32'hFFFFFFF6, 32'd0,        32, "div_neg_by0");
        run_op(ALU_DIV,   32'd7,        32'hFFFFFFFE, 32, "div_negdvsr");

        op_valid = 1'b1;
        alu_op   = ALU_MTHI;
        rs_data  = 32'h1234;
        @(negedge clk);
        chk("mthi_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        alu_op = ALU_MFHI;
        @(negedge clk);
        chk("mfhi", 64'(mf_result_o), 64'h1234);
        @(posedge clk);
        #1;
        alu_op  = ALU_MTLO;
        rs_data = 32'hABCD;
        @(posedge clk);
        #1;
        alu_op = ALU_MFLO;
        @(negedge clk);
        chk("mflo", 64'(mf_result_o), 64'hABCD);
        chk("mt_hi_kept", 64'(hi_o), 64'h1234);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        alu_op   = 6'h00;

        run_op(ALU_MULT, 32'h12345, 32'h100, 2, "mult_mflo");
        op_valid = 1'b1;
        alu_op   = ALU_MFLO;
        @(negedge clk);
        chk("mflo_after_mult", 64'(mf_result_o), 64'(cur_lo));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        alu_op   = 6'h00;

        prior    = {cur_hi, cur_lo};
        op_valid = 1'b1;
        alu_op   = ALU_DIV;
        rs_data  = 32'd1000;
        rt_data  = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        ex_flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(stall_o), 64'd0);
        chk("flush_busy_before", 64'(busy_o), 64'd1);
        @(posedge clk);
        #1;
        ex_flush = 1'b0;
        op_valid = 1'b0;
        alu_op   = 6'h00;
        @(negedge clk);
        chk("flush_idle", 64'(busy_o), 64'd0);
        chk("flush_hilo", {hi_o, lo_o}, prior);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_late_write", {hi_o, lo_o}, prior);
        run_op(ALU_DIV, 32'd1000, 32'd3, 32, "div_after_flush");

        op_valid = 1'b1;
        alu_op   = ALU_MULT;
        rs_data  = 32'd5;
        rt_data  = 32'd6;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        op_valid = 1'b0;
        alu_op   = 6'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        chk("rst_mid_stall", 64'(stall_o), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_discard", {hi_o, lo_o}, 64'd0);

        run_op(ALU_MULT, 32'hFFFF0000, 32'h00010000, 2,  "b2b_mult");
        run_op(ALU_DIVU, 32'hDEADBEEF, 32'h00001000, 32, "b2b_divu");
        @(negedge clk);
        chk("b2b_stall_end", 64'(stall_o), 64'd0);
        chk("b2b_busy_end", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
